load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of instruction decode and the ALU. Consumes the decoded memory controls (read/write, access width, zero-extend) plus the ALU-computed effective address and store data. Drives a single-outstanding request/grant/response data bus and returns aligned, extended load data, or an error, to writeback. Stalls the pipeline via a ready/valid handshake while a transaction is in flight.

Parameters:
TIMEOUT_CYCLES, 64, max cycles waited in REQ or WAIT before aborting with bus error (>=2)
ADDR_W, 32, address width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  memory op presented this cycle
in_ready_out  out  1  unit idle, op accepted when in_valid & in_ready_out
mem_read_in  in  1  load op
mem_write_in  in  1  store op
mem_width_in  in  4  0000=word, 0101=half, 1010=byte; other codes illegal
mem_zero_extend_in  in  1  1=zero-extend load, 0=sign-extend (ignored for word)
addr_in  in  ADDR_W  effective address (ALU result)
wdata_in  in  32  store data (rs2), low bits significant
flush_in  in  1  squash current op (branch/trap)
bus_req_out  out  1  request valid
bus_we_out  out  1  1=write
bus_addr_out  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_be_out  out  4  byte enables
bus_wdata_out  out  32  lane-positioned store data
bus_gnt_in  in  1  request accepted this cycle
bus_rvalid_in  in  1  read data valid
bus_rdata_in  in  32  read data word
done_out  out  1  one-cycle completion pulse
load_data_out  out  32  extended load result, valid with done_out
misaligned_out  out  1  with done_out: misaligned or illegal op
bus_err_out  out  1  with done_out: timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE; bus_req/we/be/addr/wdata=0; done/misaligned/bus_err=0; load_data=0; timeout counter=0; in_ready_out=1 (in_ready_out = state==IDLE).
- States: IDLE, CHECK, REQ, WAIT, DRAIN, DONE.
- IDLE: on in_valid, register all inputs -> CHECK. in_valid with neither read nor write -> DONE, no flags, no bus activity.
- CHECK (1 cycle): illegal = read&write, or width code not in {0000,0101,1010}; misaligned = half & addr[0], or word & addr[1:0]!=0. Illegal or misaligned -> DONE with misaligned_out=1, no bus request. Else -> REQ.
- Store lanes, off=addr[1:0]: byte be=0001<<off, wdata={4{wdata[7:0]}}; half be=0011<<off, wdata={2{wdata[15:0]}}; word be=1111, wdata unchanged. Loads drive be per same rule, wdata=0.
- REQ: bus_req_out=1; addr/we/be/wdata stable until the bus_gnt_in cycle. Gnt on store -> DONE; gnt on load -> WAIT. bus_req_out deasserts the cycle after gnt.
- WAIT: on bus_rvalid_in, word shifted right by off*8; byte/half sign- or zero-extended per zero_extend; result registered -> DONE.
- DONE: done_out=1 for exactly one cycle with result/flags -> IDLE. load_data_out holds until next done; flags clear after pulse.
- Minimum latency, accept at cycle 0, gnt same cycle REQ entered: store done_out at cycle 3; load with rvalid the cycle after gnt done_out at cycle 4.
- Timeout: counter clears on entering REQ and WAIT, increments each cycle there; reaching TIMEOUT_CYCLES -> DONE with bus_err_out=1, load_data_out=0, bus_req_out dropped.
- flush_in: in CHECK or REQ before gnt -> IDLE, no done, no bus effect (gnt and flush same cycle: gnt wins, store commits, load goes to DRAIN). In WAIT -> DRAIN. DRAIN waits for rvalid (or timeout) and discards, then -> IDLE, no done. flush in IDLE/DONE ignored; DONE pulse still emitted.
- Simultaneous rvalid and timeout expiry: rvalid wins.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_0000 -> be=1000, bus_addr=0x1000, done with load_data=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH addr=0x2002, wdata=0x0000_BEEF, gnt after 3 cycles -> req held stable, be=1100, wdata=0xBEEF_BEEF, done 1 cycle after gnt.
- LW addr=0x3001 -> no bus_req, done with misaligned_out=1; width=0011 -> same; read&write both set -> same.
- Load, gnt, no rvalid, TIMEOUT_CYCLES=4 -> done after 4 WAIT cycles, bus_err_out=1, load_data_out=0.
- Flush in REQ before gnt -> bus_req drops next cycle, no done; flush in WAIT -> DRAIN absorbs rvalid, no done, in_ready_out=1 afterwards.
- reset_n low mid-WAIT -> all outputs 0 immediately, in_ready_out=1, stray rvalid after release ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a decoded load/store into one bus transaction
// with lane steering, alignment checks, timeout, and flush handling.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready_out,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [3:0]        mem_width_in,
  input  logic              mem_zero_extend_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              flush_in,
  output logic              bus_req_out,
  output logic              bus_we_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [3:0]        bus_be_out,
  output logic [31:0]       bus_wdata_out,
  input  logic              bus_gnt_in,
  input  logic              bus_rvalid_in,
  input  logic [31:0]       bus_rdata_in,
  output logic              done_out,
  output logic [31:0]       load_data_out,
  output logic              misaligned_out,
  output logic              bus_err_out
);

  localparam logic [3:0] W_WORD = 4'b0000;
  localparam logic [3:0] W_HALF = 4'b0101;
  localparam logic [3:0] W_BYTE = 4'b1010;
  localparam int         CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic                rd_r, wr_r, zext_r;
  logic [3:0]          width_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                illegal, misal;
  logic                misaligned_r, bus_err_r;
  logic [31:0]         load_data_r;
  logic [1:0]          off;

  function automatic logic [3:0] lane_be(input logic [3:0] w, input logic [1:0] o);
    case (w)
      W_BYTE:  return 4'b0001 << o;
      W_HALF:  return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] w, input logic [31:0] d);
    case (w)
      W_BYTE:  return {4{d[7:0]}};
      W_HALF:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [3:0] w, input logic z,
                                              input logic [1:0] o, input logic [31:0] rd);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    sh = rd >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    s  = 32'sd0;
    case (w)
      W_BYTE:  begin s = b; if (z) s = {24'd0, sh[7:0]}; end
      W_HALF:  begin s = h; if (z) s = {16'd0, sh[15:0]}; end
      default: s = sh;
    endcase
    return s;
  endfunction

  assign off     = addr_r[1:0];
  assign illegal = (rd_r & wr_r) ||
                   !(width_r == W_WORD || width_r == W_HALF || width_r == W_BYTE);
  assign misal   = (width_r == W_HALF && addr_r[0]) ||
                   (width_r == W_WORD && addr_r[1:0] != 2'b00);
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (mem_read_in | mem_write_in) ? CHECK : DONE;
      CHECK: if (flush_in)              state_nxt = IDLE;
             else if (illegal | misal)  state_nxt = DONE;
             else                       state_nxt = REQ;
      // Grant beats both flush and timeout: once accepted, the bus owns the op.
      REQ:   if (bus_gnt_in)            state_nxt = wr_r ? DONE : (flush_in ? DRAIN : WAIT);
             else if (flush_in)         state_nxt = IDLE;
             else if (tmo_hit)          state_nxt = DONE;
      WAIT:  if (bus_rvalid_in)         state_nxt = flush_in ? IDLE : DONE;
             else if (flush_in)         state_nxt = DRAIN;
             else if (tmo_hit)          state_nxt = DONE;
      DRAIN: if (bus_rvalid_in | tmo_hit) state_nxt = IDLE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      zext_r       <= 1'b0;
      width_r      <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      tmo_cnt      <= '0;
      misaligned_r <= 1'b0;
      bus_err_r    <= 1'b0;
      load_data_r  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        rd_r    <= mem_read_in;
        wr_r    <= mem_write_in;
        zext_r  <= mem_zero_extend_in;
        width_r <= mem_width_in;
        addr_r  <= addr_in;
        wdata_r <= wdata_in;
      end
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == REQ || state == WAIT || state == DRAIN)
        tmo_cnt <= tmo_cnt + 1'b1;
      // Result and flags are latched only on the way into DONE.
      if (state_nxt == DONE && state != DONE) begin
        misaligned_r <= (state == CHECK);
        bus_err_r    <= (state == REQ && !bus_gnt_in) || (state == WAIT && !bus_rvalid_in);
        load_data_r  <= (state == WAIT && bus_rvalid_in) ?
                        extend_load(width_r, zext_r, off, bus_rdata_in) : 32'd0;
      end
    end
  end

  assign in_ready_out   = (state == IDLE);
  assign bus_req_out    = (state == REQ);
  assign bus_we_out     = bus_req_out & wr_r;
  assign bus_addr_out   = bus_req_out ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_out     = bus_req_out ? lane_be(width_r, off) : 4'd0;
  assign bus_wdata_out  = bus_we_out ? lane_wdata(width_r, wdata_r) : 32'd0;
  assign done_out       = (state == DONE);
  assign misaligned_out = done_out & misaligned_r;
  assign bus_err_out    = done_out & bus_err_r;
  assign load_data_out  = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with TIMEOUT_CYCLES=4.
module tb_load_store_unit;

  logic        clk, reset_n;
  logic        in_valid, in_ready_out;
  logic        mem_read_in, mem_write_in, mem_zero_extend_in, flush_in;
  logic [3:0]  mem_width_in;
  logic [31:0] addr_in, wdata_in;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_gnt_in, bus_rvalid_in;
  logic [31:0] bus_rdata_in;
  logic        done_out, misaligned_out, bus_err_out;
  logic [31:0] load_data_out;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready_out(in_ready_out),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
    .mem_zero_extend_in(mem_zero_extend_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .flush_in(flush_in), .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
    .bus_addr_out(bus_addr_out), .bus_be_out(bus_be_out), .bus_wdata_out(bus_wdata_out),
    .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in), .bus_rdata_in(bus_rdata_in),
    .done_out(done_out), .load_data_out(load_data_out), .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; afterwards the DUT sits in its first post-accept state.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] w, input logic z,
                       input logic [31:0] a, input logic [31:0] d);
    check_eq("ready_before_issue", {31'd0, in_ready_out}, 32'd1);
    in_valid = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_width_in = w;
    mem_zero_extend_in = z; addr_in = a; wdata_in = d;
    tick();
    in_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  task automatic load_ok(input string tag, input logic z, input logic [31:0] rdata,
                         input logic [31:0] exp);
    issue(1'b1, 1'b0, 4'b1010, z, 32'h0000_1003, 32'hFFFF_FFFF);
    tick();
    check_eq({tag, "_req"}, {31'd0, bus_req_out}, 32'd1);
    check_eq({tag, "_be"}, {28'd0, bus_be_out}, 32'h8);
    check_eq({tag, "_addr"}, bus_addr_out, 32'h0000_1000);
    check_eq({tag, "_we"}, {31'd0, bus_we_out}, 32'd0);
    check_eq({tag, "_wdata"}, bus_wdata_out, 32'd0);
    bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    check_eq({tag, "_req_drop"}, {31'd0, bus_req_out}, 32'd0);
    check_eq({tag, "_no_early_done"}, {31'd0, done_out}, 32'd0);
    bus_rvalid_in = 1'b1; bus_rdata_in = rdata;
    tick();
    bus_rvalid_in = 1'b0; bus_rdata_in = 32'hDEAD_BEEF;
    check_eq({tag, "_done"}, {31'd0, done_out}, 32'd1);
    check_eq({tag, "_data"}, load_data_out, exp);
    check_eq({tag, "_mis"}, {31'd0, misaligned_out}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, bus_err_out}, 32'd0);
    tick();
    check_eq({tag, "_done_clr"}, {31'd0, done_out}, 32'd0);
    check_eq({tag, "_data_hold"}, load_data_out, exp);
  endtask

  task automatic bad_op(input string tag, input logic rd, input logic wr,
                        input logic [3:0] w, input logic [31:0] a);
    issue(rd, wr, w, 1'b0, a, 32'h1234_5678);
    check_eq({tag, "_noreq_chk"}, {31'd0, bus_req_out}, 32'd0);
    tick();
    check_eq({tag, "_noreq_done"}, {31'd0, bus_req_out}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done_out}, 32'd1);
    check_eq({tag, "_mis"}, {31'd0, misaligned_out}, 32'd1);
    check_eq({tag, "_err"}, {31'd0, bus_err_out}, 32'd0);
    tick();
    check_eq({tag, "_mis_clr"}, {31'd0, misaligned_out}, 32'd0);
    check_eq({tag, "_done_clr"}, {31'd0, done_out}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_width_in = 4'd0; mem_zero_extend_in = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
    flush_in = 1'b0; bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0; bus_rdata_in = 32'd0;
    tick(); tick();
    check_eq("rst_ready", {31'd0, in_ready_out}, 32'd1);
    check_eq("rst_req", {31'd0, bus_req_out}, 32'd0);
    check_eq("rst_done", {31'd0, done_out}, 32'd0);
    check_eq("rst_data", load_data_out, 32'd0);
    reset_n = 1'b1;
    tick();

    // SH with two stalled grant cycles: request must hold steady.
    issue(1'b0, 1'b1, 4'b0101, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    check_eq("sh_chk_ready", {31'd0, in_ready_out}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("sh_req", {31'd0, bus_req_out}, 32'd1);
      check_eq("sh_we", {31'd0, bus_we_out}, 32'd1);
      check_eq("sh_be", {28'd0, bus_be_out}, 32'hC);
      check_eq("sh_addr", bus_addr_out, 32'h0000_2000);
      check_eq("sh_wdata", bus_wdata_out, 32'hBEEF_BEEF);
      if (i == 2) bus_gnt_in = 1'b1;
      tick();
    end
    bus_gnt_in = 1'b0;
    check_eq("sh_done", {31'd0, done_out}, 32'd1);
    check_eq("sh_req_drop", {31'd0, bus_req_out}, 32'd0);
    check_eq("sh_err", {31'd0, bus_err_out}, 32'd0);
    tick();
    check_eq("sh_ready", {31'd0, in_ready_out}, 32'd1);

    // SB at offset 1.
    issue(1'b0, 1'b1, 4'b1010, 1'b0, 32'h0000_5001, 32'h0000_00A5);
    tick();
    check_eq("sb_be", {28'd0, bus_be_out}, 32'h2);
    check_eq("sb_wdata", bus_wdata_out, 32'hA5A5_A5A5);
    bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    check_eq("sb_done", {31'd0, done_out}, 32'd1);
    tick();

    bad_op("lw_mis", 1'b1, 1'b0, 4'b0000, 32'h0000_3001);
    bad_op("bad_width", 1'b1, 1'b0, 4'b0011, 32'h0000_3000);
    bad_op("rd_wr", 1'b1, 1'b1, 4'b0000, 32'h0000_3000);

    // Neither read nor write: straight to a flag-free done.
    issue(1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    check_eq("nop_done", {31'd0, done_out}, 32'd1);
    check_eq("nop_mis", {31'd0, misaligned_out}, 32'd0);
    check_eq("nop_req", {31'd0, bus_req_out}, 32'd0);
    tick();

    load_ok("lb", 1'b0, 32'h80FF_0000, 32'hFFFF_FF80);
    load_ok("lbu", 1'b1, 32'h80FF_0000, 32'h0000_0080);

    // Flush while requesting, before grant.
    issue(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_6000, 32'h0);
    tick();
    check_eq("flreq_req", {31'd0, bus_req_out}, 32'd1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check_eq("flreq_req_drop", {31'd0, bus_req_out}, 32'd0);
    check_eq("flreq_ready", {31'd0, in_ready_out}, 32'd1);
    check_eq("flreq_nodone", {31'd0, done_out}, 32'd0);
    tick();
    check_eq("flreq_nodone2", {31'd0, done_out}, 32'd0);

    // Flush in WAIT: DRAIN swallows the response.
    issue(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_6004, 32'h0);
    tick();
    bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check_eq("flwait_busy", {31'd0, in_ready_out}, 32'd0);
    check_eq("flwait_nodone", {31'd0, done_out}, 32'd0);
    bus_rvalid_in = 1'b1; bus_rdata_in = 32'h1111_2222;
    tick();
    bus_rvalid_in = 1'b0;
    check_eq("flwait_nodone2", {31'd0, done_out}, 32'd0);
    check_eq("flwait_ready", {31'd0, in_ready_out}, 32'd1);
    check_eq("flwait_data_hold", load_data_out, 32'h0000_0080);

    // Grant but no response: four WAIT cycles then bus error.
    issue(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_4000, 32'h0);
    tick();
    bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("tmo_wait", {31'd0, done_out}, 32'd0);
    end
    tick();
    check_eq("tmo_done", {31'd0, done_out}, 32'd1);
    check_eq("tmo_err", {31'd0, bus_err_out}, 32'd1);
    check_eq("tmo_data", load_data_out, 32'd0);
    check_eq("tmo_req", {31'd0, bus_req_out}, 32'd0);
    tick();
    check_eq("tmo_err_clr", {31'd0, bus_err_out}, 32'd0);

    // A good load to make load_data nonzero, then reset mid-WAIT.
    load_ok("lb2", 1'b0, 32'h7F00_0000, 32'h0000_007F);
    issue(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_7000, 32'h0);
    tick();
    bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    check_eq("rstw_busy", {31'd0, in_ready_out}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("rstw_ready", {31'd0, in_ready_out}, 32'd1);
    check_eq("rstw_data", load_data_out, 32'd0);
    check_eq("rstw_outs", {27'd0, done_out, misaligned_out, bus_err_out, bus_req_out,
                           bus_we_out}, 32'd0);
    tick();
    reset_n = 1'b1;
    bus_rvalid_in = 1'b1; bus_rdata_in = 32'h5555_AAAA;
    tick();
    bus_rvalid_in = 1'b0;
    check_eq("rstw_stray_done", {31'd0, done_out}, 32'd0);
    check_eq("rstw_stray_ready", {31'd0, in_ready_out}, 32'd1);
    tick();
    check_eq("rstw_stray_data", load_data_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
